// File: rtl/neo_iack_responder.sv
// rtl/neo_iack_responder.sv - 68000 interrupt level filter and IACK autovector/spurious responder
module neo_iack_responder #(
   parameter int unsigned VPA_DELAY = 1,
   parameter bit          AUTO_ACK  = 1'b1
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       CLK_EN,
   input  logic       IPL0,
   input  logic       IPL1,
   input  logic [2:0] FC,
   input  logic       nAS,
   input  logic [2:0] A,
   output logic [2:0] nIPL,
   output logic       nVPA,
   output logic       nBERR,
   output logic       WR_ACK,
   output logic [2:0] ACK_BITS,
   output logic [2:0] IACK_LEVEL,
   output logic [7:0] IACK_COUNT
);

   localparam logic [3:0] DELAY_INIT = 4'(VPA_DELAY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_VPA,
      S_SPUR
   } state_t;

   state_t     state, state_n;
   logic [2:0] raw, s1, filt;
   logic [2:0] req, req_n;
   logic [3:0] cnt, cnt_n;
   logic       nvpa_n, nberr_n, wr_ack_n;
   logic [2:0] ack_n, level_n;
   logic [7:0] count_n;
   logic [2:0] req_onehot;

   assign raw  = ~{1'b1, IPL1, IPL0};
   assign nIPL = ~filt;

   always_comb begin
      req_onehot = 3'b000;
      case (req)
         3'd3:    req_onehot = 3'b001;
         3'd2:    req_onehot = 3'b010;
         3'd1:    req_onehot = 3'b100;
         default: req_onehot = 3'b000;
      endcase
   end

   always_comb begin
      state_n  = state;
      req_n    = req;
      cnt_n    = cnt;
      nvpa_n   = nVPA;
      nberr_n  = nBERR;
      wr_ack_n = 1'b0;
      ack_n    = 3'b000;
      level_n  = IACK_LEVEL;
      count_n  = IACK_COUNT;
      case (state)
         S_IDLE: begin
            if (FC == 3'b111 && !nAS) begin
               req_n = A;
               if (A == filt && A != 3'd0) begin
                  state_n = S_DELAY;
                  cnt_n   = DELAY_INIT;
               end else begin
                  state_n = S_SPUR;
               end
            end
         end
         S_DELAY: begin
            if (nAS) begin
               state_n = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_n = S_VPA;
               nvpa_n  = 1'b0;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         S_VPA: begin
            if (nAS) begin
               state_n = S_IDLE;
               nvpa_n  = 1'b1;
               level_n = req;
               count_n = IACK_COUNT + 8'd1;
               if (AUTO_ACK) begin
                  wr_ack_n = 1'b1;
                  ack_n    = req_onehot;
               end
            end
         end
         S_SPUR: begin
            // nBERR trails SPUR entry by one tick so it lands after T+1
            if (nAS) begin
               state_n = S_IDLE;
               nberr_n = 1'b1;
            end else begin
               nberr_n = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state      <= S_IDLE;
         s1         <= 3'd0;
         filt       <= 3'd0;
         req        <= 3'd0;
         cnt        <= 4'd0;
         nVPA       <= 1'b1;
         nBERR      <= 1'b1;
         WR_ACK     <= 1'b0;
         ACK_BITS   <= 3'b000;
         IACK_LEVEL <= 3'd0;
         IACK_COUNT <= 8'd0;
      end else if (CLK_EN) begin
         s1 <= raw;
         if (raw == s1) begin
            filt <= raw;
         end
         state      <= state_n;
         req        <= req_n;
         cnt        <= cnt_n;
         nVPA       <= nvpa_n;
         nBERR      <= nberr_n;
         WR_ACK     <= wr_ack_n;
         ACK_BITS   <= ack_n;
         IACK_LEVEL <= level_n;
         IACK_COUNT <= count_n;
      end
   end

endmodule

// File: tb/tb_neo_iack_responder.sv
// tb/tb_neo_iack_responder.sv - directed vector bench for neo_iack_responder
module tb_neo_iack_responder;

   logic       clk = 1'b0;
   logic       nreset;
   logic       clk_en;
   logic       ipl0, ipl1;
   logic [2:0] fc;
   logic       nas;
   logic [2:0] a;

   logic [2:0] nipl_a, nipl_b;
   logic       nvpa_a, nvpa_b, nberr_a, nberr_b, wr_ack_a, wr_ack_b;
   logic [2:0] ack_a, ack_b, level_a, level_b;
   logic [7:0] count_a, count_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // dut_a: short delay with auto-ack; dut_b: long delay, no auto-ack
   neo_iack_responder #(.VPA_DELAY(1), .AUTO_ACK(1'b1)) dut_a (
      .CLK(clk), .nRESET(nreset), .CLK_EN(clk_en), .IPL0(ipl0), .IPL1(ipl1),
      .FC(fc), .nAS(nas), .A(a), .nIPL(nipl_a), .nVPA(nvpa_a), .nBERR(nberr_a),
      .WR_ACK(wr_ack_a), .ACK_BITS(ack_a), .IACK_LEVEL(level_a), .IACK_COUNT(count_a)
   );

   neo_iack_responder #(.VPA_DELAY(4), .AUTO_ACK(1'b0)) dut_b (
      .CLK(clk), .nRESET(nreset), .CLK_EN(clk_en), .IPL0(ipl0), .IPL1(ipl1),
      .FC(fc), .nAS(nas), .A(a), .nIPL(nipl_b), .nVPA(nvpa_b), .nBERR(nberr_b),
      .WR_ACK(wr_ack_b), .ACK_BITS(ack_b), .IACK_LEVEL(level_b), .IACK_COUNT(count_b)
   );

   typedef struct {
      logic       ipl1;
      logic       ipl0;
      logic [2:0] exp_nipl;
   } fvec_t;

   fvec_t fv[12];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ipl(input logic i1, input logic i0);
      ipl1 = i1;
      ipl0 = i0;
      tick();
      tick();
   endtask

   initial begin
      int waited;
      int timeouts;
      int b_ack_seen;

      fv[0]  = '{1'b0, 1'b1, 3'b111};
      fv[1]  = '{1'b1, 1'b1, 3'b111};
      fv[2]  = '{1'b0, 1'b1, 3'b111};
      fv[3]  = '{1'b0, 1'b1, 3'b101};
      fv[4]  = '{1'b0, 1'b1, 3'b101};
      fv[5]  = '{1'b0, 1'b0, 3'b101};
      fv[6]  = '{1'b0, 1'b0, 3'b100};
      fv[7]  = '{1'b1, 1'b0, 3'b100};
      fv[8]  = '{1'b1, 1'b0, 3'b110};
      fv[9]  = '{1'b1, 1'b1, 3'b110};
      fv[10] = '{1'b1, 1'b0, 3'b110};
      fv[11] = '{1'b1, 1'b0, 3'b110};

      nreset = 1'b0;
      clk_en = 1'b1;
      ipl1 = 1'b1;
      ipl0 = 1'b1;
      fc = 3'd0;
      nas = 1'b1;
      a = 3'd0;
      #12;
      check("rst_nipl", 8'(nipl_a), 8'h7);
      check("rst_nvpa", 8'(nvpa_a), 8'h1);
      check("rst_nberr", 8'(nberr_a), 8'h1);
      check("rst_wr_ack", 8'(wr_ack_a), 8'h0);
      check("rst_ack_bits", 8'(ack_a), 8'h0);
      check("rst_level", 8'(level_a), 8'h0);
      check("rst_count", count_a, 8'h0);
      nreset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         ipl1 = fv[i].ipl1;
         ipl0 = fv[i].ipl0;
         tick();
         check($sformatf("filt_%0d", i), 8'(nipl_a), 8'(fv[i].exp_nipl));
         check($sformatf("idle_nvpa_%0d", i), 8'(nvpa_a), 8'h1);
      end

      // autovector level 2
      set_ipl(1'b0, 1'b1);
      check("av_nipl", 8'(nipl_a), 8'h5);
      fc = 3'b111; nas = 1'b0; a = 3'd2;
      tick();
      check("av_a_t0", 8'(nvpa_a), 8'h1);
      tick();
      check("av_a_t1", 8'(nvpa_a), 8'h1);
      tick();
      check("av_a_t2", 8'(nvpa_a), 8'h0);
      check("av_b_t2", 8'(nvpa_b), 8'h1);
      tick();
      tick();
      check("av_b_t4", 8'(nvpa_b), 8'h1);
      tick();
      check("av_b_t5", 8'(nvpa_b), 8'h0);
      check("av_a_hold", 8'(nvpa_a), 8'h0);
      nas = 1'b1; fc = 3'd0;
      tick();
      check("av_done_nvpa", 8'(nvpa_a), 8'h1);
      check("av_wr_ack", 8'(wr_ack_a), 8'h1);
      check("av_ack_bits", 8'(ack_a), 8'h2);
      check("av_level", 8'(level_a), 8'h2);
      check("av_count", count_a, 8'h1);
      check("av_b_nvpa", 8'(nvpa_b), 8'h1);
      check("av_b_wr_ack", 8'(wr_ack_b), 8'h0);
      check("av_b_count", count_b, 8'h1);
      clk_en = 1'b0;
      repeat (3) tick();
      check("freeze_wr_ack", 8'(wr_ack_a), 8'h1);
      check("freeze_ack_bits", 8'(ack_a), 8'h2);
      clk_en = 1'b1;
      tick();
      check("pulse_end_wr_ack", 8'(wr_ack_a), 8'h0);
      check("pulse_end_ack_bits", 8'(ack_a), 8'h0);

      // spurious: filtered level 1, CPU acknowledges level 3
      set_ipl(1'b1, 1'b0);
      check("sp_nipl", 8'(nipl_a), 8'h6);
      fc = 3'b111; nas = 1'b0; a = 3'd3;
      tick();
      check("sp_t0_nberr", 8'(nberr_a), 8'h1);
      tick();
      check("sp_t1_nberr_a", 8'(nberr_a), 8'h0);
      check("sp_t1_nberr_b", 8'(nberr_b), 8'h0);
      tick();
      check("sp_t2_nberr", 8'(nberr_a), 8'h0);
      check("sp_nvpa", 8'(nvpa_a), 8'h1);
      nas = 1'b1; fc = 3'd0;
      tick();
      check("sp_release", 8'(nberr_a), 8'h1);
      check("sp_wr_ack", 8'(wr_ack_a), 8'h0);
      check("sp_count", count_a, 8'h1);

      // abort during delay
      fc = 3'b111; nas = 1'b0; a = 3'd1;
      tick();
      tick();
      check("ab_t1_nvpa_b", 8'(nvpa_b), 8'h1);
      nas = 1'b1; fc = 3'd0;
      tick();
      repeat (6) begin
         tick();
         check("ab_nvpa_b", 8'(nvpa_b), 8'h1);
         check("ab_nvpa_a", 8'(nvpa_a), 8'h1);
      end
      check("ab_count_b", count_b, 8'h1);
      check("ab_count_a", count_a, 8'h1);
      check("ab_wr_ack", 8'(wr_ack_a), 8'h0);

      // asynchronous reset while nVPA is asserted
      fc = 3'b111; nas = 1'b0; a = 3'd1;
      tick();
      tick();
      tick();
      check("rv_nvpa_low", 8'(nvpa_a), 8'h0);
      #2;
      nreset = 1'b0;
      #1;
      check("rv_nvpa", 8'(nvpa_a), 8'h1);
      check("rv_nberr", 8'(nberr_a), 8'h1);
      check("rv_wr_ack", 8'(wr_ack_a), 8'h0);
      check("rv_nipl", 8'(nipl_a), 8'h7);
      check("rv_level", 8'(level_a), 8'h0);
      check("rv_count", count_a, 8'h0);
      nas = 1'b1; fc = 3'd0;
      #3;
      nreset = 1'b1;

      // 256 level-3 autovector cycles wrap the count
      set_ipl(1'b0, 1'b0);
      check("wr_nipl", 8'(nipl_a), 8'h4);
      timeouts = 0;
      b_ack_seen = 0;
      for (int i = 0; i < 256; i++) begin
         fc = 3'b111; nas = 1'b0; a = 3'd3;
         tick();
         waited = 0;
         while (nvpa_b && waited < 20) begin
            tick();
            if (wr_ack_b) b_ack_seen++;
            waited++;
         end
         if (nvpa_b) timeouts++;
         nas = 1'b1; fc = 3'd0;
         tick();
         if (wr_ack_b) b_ack_seen++;
         if (i == 0) begin
            check("wr_first_ack_bits", 8'(ack_a), 8'h1);
            check("wr_first_count_b", count_b, 8'h1);
         end
      end
      check("wr_timeouts", 8'(timeouts), 8'h0);
      check("wr_count_b", count_b, 8'h0);
      check("wr_level_b", 8'(level_b), 8'h3);
      check("wr_count_a", count_a, 8'h0);
      check("wr_b_no_ack", 8'(b_ack_seen), 8'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neo_iack_responder.md
# neo_iack_responder

CPU-side counterpart of the interrupt controller's IPL0/IPL1 outputs. It takes the encoded interrupt request and presents a 68000-style filtered level on nIPL[2:0]. It then decodes the CPU's interrupt-acknowledge bus cycle and answers it with autovector (nVPA) or spurious (nBERR) signalling. Optionally it writes the matching acknowledge bits back to the interrupt controller's WR_ACK/ACK_BITS inputs, closing the request/acknowledge loop without software.

## Interface
Parameters:
- VPA_DELAY, 1: CLK_EN ticks between IACK detection and nVPA assertion (0..15).
- AUTO_ACK, 1: 1 = emit WR_ACK/ACK_BITS on each completed autovector cycle; 0 = never drive WR_ACK.

Ports (clock and reset first):
- CLK  in  1  system clock; the block has one clock.
- nRESET  in  1  reset, asynchronous, active-low.
- CLK_EN  in  1  CPU clock-enable tick; all state advances only on CLK edges with CLK_EN=1.
- IPL0, IPL1  in  1 each  encoded request from the interrupt controller. Raw level = ~{1, IPL1, IPL0}, giving 3 = reset, 2 = timer, 1 = VBL, 0 = none.
- FC  in  3  CPU function code.
- nAS  in  1  CPU address strobe.
- A  in  3  CPU address bits 3:1 (requested level during IACK).
- nIPL  out  3  filtered level to the CPU core, active-low.
- nVPA  out  1  autovector response, active-low.
- nBERR  out  1  spurious-interrupt response, active-low.
- WR_ACK  out  1  acknowledge write strobe to the interrupt controller.
- ACK_BITS  out  3  one-hot ack: bit0 = level 3, bit1 = level 2, bit2 = level 1.
- IACK_LEVEL  out  3  level of the last completed autovector cycle.
- IACK_COUNT  out  8  completed autovector cycles, wraps 255 -> 0.

## Operation
- Reset values: nIPL=3'b111, nVPA=1, nBERR=1, WR_ACK=0, ACK_BITS=0, IACK_LEVEL=0, IACK_COUNT=0, state IDLE, filter registers 0. Reset is asynchronous and effective mid-cycle: any asserted nVPA, nBERR or WR_ACK releases immediately.
- Level filter:
  - Each tick, the raw level is stored in S1.
  - If raw == S1 on that tick, FILT <= raw.
  - nIPL = ~FILT.
  - A single-tick glitch never reaches nIPL.
- State machine, evaluated on ticks:
  - IDLE: when FC==3'b111 and nAS==0, latch REQ <= A. If REQ==FILT and REQ!=0, go to DELAY with CNT <= VPA_DELAY; otherwise go to SPUR.
  - DELAY: if nAS==1, go to IDLE with no ack and no count. Else if CNT==0, go to VPA. Else CNT--.
  - VPA: nVPA=0. When nAS==1 sampled, go to IDLE and complete: nVPA=1, IACK_LEVEL <= REQ, IACK_COUNT++, and if AUTO_ACK, WR_ACK=1 with ACK_BITS one-hot for REQ for exactly one tick period.
  - SPUR: nBERR=0 until nAS==1 sampled, then go to IDLE. No ack, no count.
- REQ is latched at detection. FILT changing during DELAY or VPA does not alter the response.
- A new IACK is only recognised from IDLE, so nAS must be seen high between cycles.
- While WR_ACK is high, ACK_BITS holds its one-hot value. Otherwise ACK_BITS=0.

## Timing
- All outputs are registered and change only on CLK edges with CLK_EN=1, except on asynchronous reset.
- Filter latency: a raw change at tick T is visible on nIPL after tick T+1.
- IACK detected at tick T: nVPA goes low after tick T+1+VPA_DELAY. nBERR goes low after tick T+1.
- nAS high sampled at tick U in VPA: nVPA rises, and WR_ACK, IACK_LEVEL and IACK_COUNT update after tick U. WR_ACK falls after tick U+1.
- Ticks with CLK_EN=0 freeze all state, including the WR_ACK pulse.

## Test plan
- Filter: drive IPL1/IPL0 = 0/1 for 1 tick, then 1/1 -> nIPL stays 3'b111. Then hold 0/1 for 3 ticks -> nIPL=3'b101 after the 2nd tick.
- Autovector: FILT=2, VPA_DELAY=1, IACK with A=2 at tick T -> nVPA low after T+2. nAS high at U -> nVPA=1, WR_ACK=1 with ACK_BITS=3'b010 for one tick, IACK_LEVEL=2, IACK_COUNT=1.
- Spurious: FILT=1, IACK with A=3 -> nBERR low after T+1 and released when nAS is high; nVPA stays 1, WR_ACK stays 0, count unchanged.
- Abort: VPA_DELAY=4, nAS rises 2 ticks after detection -> nVPA never asserts, no WR_ACK, count unchanged.
- Wrap and AUTO_ACK=0: 256 completed level-3 cycles -> IACK_COUNT=0, IACK_LEVEL=3, WR_ACK never asserted.
- Reset mid-VPA: drop nRESET while nVPA=0 -> nVPA=1 and all outputs at reset values without waiting for a CLK edge.
